// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single writeback/wakeup bus among the execution units.
//
// Each unit posts completed results into a small holding FIFO; a round-robin
// arbiter grants one FIFO head per cycle onto the bus, and registered busy
// flags tell the scheduler to stop issuing to a unit whose results cannot drain.
//
// Handshake: done_[k] low at a rising edge offers one result from unit k. It
// is accepted if FIFO k has room, or is full but pops at that same edge.
// Otherwise it is dropped and ovf_err is set. wb_e_ low means the bus carries
// a valid result this cycle. The bus has no ready: the granted head always
// retires at the end of the cycle.
//
// Ports:
//   clk, reset_     clock; asynchronous active-low reset
//   flush_          active-low pipeline flush (empties all FIFOs)
//   done_           per-unit result valid, active-low
//   done_rd         per-unit destination register
//   done_data       per-unit result data
//   wb_e_           writeback valid, active-low
//   wb_rd, wb_data  granted result
//   wb_unit         granted unit
//   exe_busy        registered per-unit busy flags
//   ovf_err         sticky overflow flag, active-high

package wb_arbiter_pkg;
  typedef logic [5:0] RegFile_t;

  typedef enum logic [2:0] {
    UNIT_ALU  = 3'd0,
    UNIT_DIV  = 3'd1,
    UNIT_FPU  = 3'd2,
    UNIT_FDIV = 3'd3,
    UNIT_CSR  = 3'd4,
    UNIT_MEM  = 3'd5
  } ExeUnit_t;

  // alu is bit 0 so the struct lines up with the unit index order.
  typedef struct packed {
    logic mem;
    logic csr;
    logic fdiv;
    logic fpu;
    logic div;
    logic alu;
  } ExeBusy_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int UNITS = 6,
  parameter int DEPTH = 2,
  parameter int DATA  = 32,
  localparam int U    = $clog2(UNITS)
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              flush_,
  input  logic [UNITS-1:0]  done_,
  input  RegFile_t          done_rd [UNITS],
  input  logic [DATA-1:0]   done_data [UNITS],
  output logic              wb_e_,
  output RegFile_t          wb_rd,
  output logic [DATA-1:0]   wb_data,
  output ExeUnit_t          wb_unit,
  output ExeBusy_t          exe_busy,
  output logic              ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  RegFile_t          rd_mem   [UNITS][DEPTH];
  logic [DATA-1:0]   data_mem [UNITS][DEPTH];
  logic [PW-1:0]     wr_ptr   [UNITS];
  logic [PW-1:0]     rd_ptr   [UNITS];
  logic [CW-1:0]     count    [UNITS];
  logic [CW-1:0]     next_count [UNITS];
  logic [U-1:0]      rr_ptr;
  logic [UNITS-1:0]  busy_q;
  logic [UNITS-1:0]  nonempty;
  logic [UNITS-1:0]  push;
  logic [UNITS-1:0]  pop;
  logic [UNITS-1:0]  drop;
  logic              gnt_valid;
  logic [U-1:0]      gnt;

  always_comb begin
    for (int k = 0; k < UNITS; k++) nonempty[k] = (count[k] != '0);
  end

  // Round-robin search starting at rr_ptr. UNITS need not be a power of two,
  // so the candidate index wraps explicitly.
  always_comb begin
    int           idx;
    logic [U-1:0] cand;
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < UNITS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= UNITS) idx = idx - UNITS;
      cand = U'(idx);
      if (!gnt_valid && nonempty[cand]) begin
        gnt_valid = 1'b1;
        gnt       = cand;
      end
    end
  end

  // Bus is driven straight from the granted head, so a result pushed at an
  // edge appears on the bus no earlier than the following cycle.
  always_comb begin
    wb_e_   = !gnt_valid;
    wb_rd   = gnt_valid ? rd_mem[gnt][rd_ptr[gnt]]   : '0;
    wb_data = gnt_valid ? data_mem[gnt][rd_ptr[gnt]] : '0;
    wb_unit = gnt_valid ? ExeUnit_t'(gnt) : UNIT_ALU;
  end

  // A full FIFO that pops this edge can still take a push; flush discards
  // every push offered in the same cycle.
  always_comb begin
    for (int k = 0; k < UNITS; k++) begin
      pop[k]        = gnt_valid && (gnt == U'(k));
      push[k]       = flush_ && !done_[k] && ((count[k] != CW'(DEPTH)) || pop[k]);
      drop[k]       = flush_ && !done_[k] && (count[k] == CW'(DEPTH)) && !pop[k];
      next_count[k] = count[k] + CW'(push[k]) - CW'(pop[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int k = 0; k < UNITS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
      rr_ptr  <= '0;
      busy_q  <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (|drop) ovf_err <= 1'b1;
      if (!flush_) begin
        for (int k = 0; k < UNITS; k++) begin
          wr_ptr[k] <= '0;
          rd_ptr[k] <= '0;
          count[k]  <= '0;
        end
        rr_ptr <= '0;
        busy_q <= '0;
      end else begin
        for (int k = 0; k < UNITS; k++) begin
          if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
          if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
          count[k] <= next_count[k];
          // One slot stays free for a result already in flight.
          busy_q[k] <= (next_count[k] >= CW'(DEPTH - 1));
        end
        if (gnt_valid) rr_ptr <= (gnt == U'(UNITS - 1)) ? '0 : gnt + U'(1);
      end
    end
  end

  // Storage needs no reset: the bus only reads entries covered by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < UNITS; k++) begin
      if (push[k]) begin
        rd_mem[k][wr_ptr[k]]   <= done_rd[k];
        data_mem[k][wr_ptr[k]] <= done_data[k];
      end
    end
  end

  assign exe_busy = ExeBusy_t'(busy_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model through an expected queue.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int UNITS = 6;
  localparam int DEPTH = 2;
  localparam int DATA  = 32;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset_;
  logic             flush_;
  logic [UNITS-1:0] done_;
  RegFile_t         done_rd [UNITS];
  logic [DATA-1:0]  done_data [UNITS];
  logic             wb_e_;
  RegFile_t         wb_rd;
  logic [DATA-1:0]  wb_data;
  ExeUnit_t         wb_unit;
  ExeBusy_t         exe_busy;
  logic             ovf_err;

  always #5 clk = ~clk;

  wb_arbiter #(.UNITS(UNITS), .DEPTH(DEPTH), .DATA(DATA)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .flush_   (flush_),
    .done_    (done_),
    .done_rd  (done_rd),
    .done_data(done_data),
    .wb_e_    (wb_e_),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_unit  (wb_unit),
    .exe_busy (exe_busy),
    .ovf_err  (ovf_err)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [37:0]      mq [UNITS][$];   // per-unit pending results {rd, data}
  int               m_rr;
  bit               m_gv;
  int               m_gnt;
  logic [UNITS-1:0] m_busy;
  bit               m_ovf;
  logic [40:0]      exp_q [$];       // {unit, rd, data} expected this cycle
  bit               mon_en;
  int               n_checks;
  int               n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < UNITS; k++) mq[k].delete();
    m_rr   = 0;
    m_gv   = 0;
    m_gnt  = 0;
    m_busy = '0;
    m_ovf  = 0;
    exp_q.delete();
  endtask

  // What the bus must show in the current cycle: the first pending unit
  // found scanning upward from the round-robin position.
  task automatic model_bus();
    m_gv = 0;
    for (int i = 0; i < UNITS; i++) begin
      int k;
      k = (m_rr + i) % UNITS;
      if (!m_gv && mq[k].size() > 0) begin
        m_gv  = 1;
        m_gnt = k;
      end
    end
    if (m_gv) exp_q.push_back({3'(m_gnt), mq[m_gnt][0]});
  endtask

  // Apply one clock edge to the model using the inputs the DUT just sampled.
  task automatic model_edge();
    if (!flush_) begin
      for (int k = 0; k < UNITS; k++) mq[k].delete();
      m_rr   = 0;
      m_busy = '0;
    end else begin
      if (m_gv) begin
        void'(mq[m_gnt].pop_front());
        m_rr = (m_gnt + 1) % UNITS;
      end
      for (int k = 0; k < UNITS; k++) begin
        if (!done_[k]) begin
          if (mq[k].size() < DEPTH) mq[k].push_back({done_rd[k], done_data[k]});
          else m_ovf = 1;
        end
      end
      for (int k = 0; k < UNITS; k++) m_busy[k] = (mq[k].size() >= DEPTH - 1);
    end
  endtask

  // Monitor: compares every cycle, away from the active edge.
  always @(negedge clk) begin : monitor
    logic [40:0] e;
    bit          exp_v;
    if (mon_en) begin
      chk("exe_busy", 64'(exe_busy), 64'(m_busy));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
      exp_v = (exp_q.size() != 0);
      chk("wb_valid", 64'(!wb_e_), 64'(exp_v));
      if (!wb_e_ && exp_v) begin
        e = exp_q.pop_front();
        chk("wb_entry", 64'({wb_unit, wb_rd, wb_data}), 64'(e));
      end else if (exp_v) begin
        exp_q.delete();
      end
      if (wb_e_) chk("idle_bus", 64'({wb_unit, wb_rd, wb_data}), 64'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    done_  = '1;
    flush_ = 1'b1;
    for (int k = 0; k < UNITS; k++) begin
      done_rd[k]   = '0;
      done_data[k] = '0;
    end
  endtask

  task automatic post(input int k, input int rd, input logic [31:0] data);
    done_[k]     = 1'b0;
    done_rd[k]   = RegFile_t'(rd);
    done_data[k] = data;
  endtask

  // One clock: inputs were set before; returns 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_bus();
  endtask

  // Called 1 time unit after an edge: asserts reset mid-cycle.
  task automatic do_reset();
    #2;
    reset_ = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("async_wb_e_", 64'(wb_e_), 64'(1));
    chk("async_busy", 64'(exe_busy), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    model_bus();
    mon_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          prev;
    int          ndiv;
    logic [5:0]  div_rd [$];

    n_checks = 0;
    n_pass   = 0;
    mon_en   = 0;
    reset_   = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    model_bus();
    mon_en = 1'b1;

    // Reset state
    chk("rst_wb_e_", 64'(wb_e_), 64'(1));
    chk("rst_wb_rd", 64'(wb_rd), 64'(0));
    chk("rst_wb_data", 64'(wb_data), 64'(0));
    chk("rst_wb_unit", 64'(wb_unit), 64'(0));
    chk("rst_busy", 64'(exe_busy), 64'(0));
    chk("rst_ovf", 64'(ovf_err), 64'(0));
    chk("rst_rr", 64'(dut.rr_ptr), 64'(0));

    // Single result
    post(0, 5, 32'h1234);
    step();
    idle_inputs();
    chk("single_wb_e_", 64'(wb_e_), 64'(0));
    chk("single_rd", 64'(wb_rd), 64'(5));
    chk("single_data", 64'(wb_data), 64'(32'h1234));
    chk("single_unit", 64'(wb_unit), 64'(UNIT_ALU));
    chk("single_busy_t1", 64'(exe_busy), 64'(6'b000001));
    step();
    chk("single_idle_t2", 64'(wb_e_), 64'(1));
    chk("single_busy_t2", 64'(exe_busy), 64'(0));
    chk("single_rr", 64'(dut.rr_ptr), 64'(1));

    // Simultaneous ALU + MEM
    do_reset();
    post(0, 7, 32'hA1A1);
    post(5, 9, 32'h5E5E);
    step();
    idle_inputs();
    chk("simul_t1_unit", 64'(wb_unit), 64'(UNIT_ALU));
    step();
    chk("simul_t2_valid", 64'(wb_e_), 64'(0));
    chk("simul_t2_unit", 64'(wb_unit), 64'(UNIT_MEM));
    step();
    chk("simul_t3_idle", 64'(wb_e_), 64'(1));
    chk("simul_rr_wrap", 64'(dut.rr_ptr), 64'(0));

    // Fairness: every unit pushes whenever it is not busy
    do_reset();
    prev = -1;
    for (int c = 0; c < 24; c++) begin
      for (int k = 0; k < UNITS; k++) begin
        if (!exe_busy[k]) post(k, $urandom_range(0, 63), $urandom);
        else done_[k] = 1'b1;
      end
      step();
      idle_inputs();
      if (!wb_e_) begin
        if (prev >= 0) chk("fair_rotate", 64'(wb_unit), 64'((prev + 1) % UNITS));
        prev = int'(wb_unit);
      end
    end
    chk("fair_no_ovf", 64'(ovf_err), 64'(0));
    repeat (8) step();

    // Back-pressure and overflow on DIV
    do_reset();
    for (int k = 2; k < UNITS; k++) post(k, 30 + k, $urandom);
    step();
    idle_inputs();
    post(1, 11, 32'hD001);
    step();
    idle_inputs();
    post(1, 12, 32'hD002);
    step();
    idle_inputs();
    chk("bp_div_busy", 64'(exe_busy.div), 64'(1));
    post(1, 13, 32'hD003);
    step();
    idle_inputs();
    chk("bp_ovf_set", 64'(ovf_err), 64'(1));
    for (int c = 0; c < 8; c++) begin
      if (!wb_e_ && wb_unit == UNIT_DIV) div_rd.push_back(wb_rd);
      step();
    end
    ndiv = div_rd.size();
    chk("bp_div_count", 64'(ndiv), 64'(2));
    if (ndiv == 2) begin
      chk("bp_div_first", 64'(div_rd[0]), 64'(11));
      chk("bp_div_second", 64'(div_rd[1]), 64'(12));
    end
    chk("bp_ovf_sticky", 64'(ovf_err), 64'(1));

    // Flush with FPU result offered in the flush cycle
    do_reset();
    post(0, 20, 32'hF000);
    post(1, 21, 32'hF001);
    post(3, 23, 32'hF003);
    step();
    idle_inputs();
    flush_ = 1'b0;
    post(2, 22, 32'hF002);
    step();
    idle_inputs();
    chk("flush_idle", 64'(wb_e_), 64'(1));
    chk("flush_busy", 64'(exe_busy), 64'(0));
    chk("flush_rr", 64'(dut.rr_ptr), 64'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("flush_no_fpu", 64'(wb_e_), 64'(1));
    end

    // Async reset while FIFOs hold entries
    post(0, 1, 32'h1);
    post(2, 2, 32'h2);
    post(4, 4, 32'h4);
    step();
    idle_inputs();
    do_reset();

    // Randomized traffic with occasional flushes and resets
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < UNITS; k++) begin
        if ($urandom_range(0, 99) < 35) post(k, $urandom_range(0, 63), $urandom);
        else done_[k] = 1'b1;
      end
      flush_ = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      step();
      idle_inputs();
      if (c == 150 || c == 300) do_reset();
    end

    idle_inputs();
    repeat (14) step();
    chk("final_drained", 64'(wb_e_), 64'(1));

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
